// File: rtl/iter_alu.sv
// MIPS ALU: single-cycle ALU/shift/compare path plus an iterative
// multiply/divide unit (shift-add / restoring) writing HI/LO.
module iter_alu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [4:0]       ALUOp,
   input  logic [SHW-1:0]   shamt,
   input  logic             start,
   output logic [WIDTH-1:0] Res,
   output logic             ZF,
   output logic             OV,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned W2         = 2 * WIDTH;
   localparam logic [SHW-1:0] LAST_CNT = SHW'(WIDTH - 1);

   localparam logic [4:0] OP_ADDU  = 5'd0;
   localparam logic [4:0] OP_SUBU  = 5'd1;
   localparam logic [4:0] OP_ADD   = 5'd2;
   localparam logic [4:0] OP_SUB   = 5'd3;
   localparam logic [4:0] OP_AND   = 5'd4;
   localparam logic [4:0] OP_OR    = 5'd5;
   localparam logic [4:0] OP_XOR   = 5'd6;
   localparam logic [4:0] OP_NOR   = 5'd7;
   localparam logic [4:0] OP_SLT   = 5'd8;
   localparam logic [4:0] OP_SLTU  = 5'd9;
   localparam logic [4:0] OP_SLL   = 5'd10;
   localparam logic [4:0] OP_SRL   = 5'd11;
   localparam logic [4:0] OP_SRA   = 5'd12;
   localparam logic [4:0] OP_SLLV  = 5'd13;
   localparam logic [4:0] OP_SRLV  = 5'd14;
   localparam logic [4:0] OP_SRAV  = 5'd15;
   localparam logic [4:0] OP_LUI   = 5'd16;
   localparam logic [4:0] OP_MULT  = 5'd17;
   localparam logic [4:0] OP_MULTU = 5'd18;
   localparam logic [4:0] OP_DIV   = 5'd19;
   localparam logic [4:0] OP_DIVU  = 5'd20;
   localparam logic [4:0] OP_MFHI  = 5'd21;
   localparam logic [4:0] OP_MFLO  = 5'd22;
   localparam logic [4:0] OP_MTHI  = 5'd23;
   localparam logic [4:0] OP_MTLO  = 5'd24;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t           r_state, w_state_nx;
   logic             w_go_mul, w_go_div;
   logic [SHW-1:0]   r_cnt;
   logic [WIDTH-1:0] r_acc, r_q, r_m, r_hi, r_lo;
   logic             r_busy, r_done, r_is_div, r_neg_q, r_neg_r, r_dvz;

   logic [WIDTH-1:0] w_sum, w_diff;
   logic [SHW-1:0]   w_sa;
   logic             w_sgn_op, w_a_neg, w_b_neg;
   logic [WIDTH-1:0] w_amag, w_bmag;
   logic [WIDTH:0]   w_mul_sum, w_div_sh, w_div_diff;
   logic             w_div_ge;
   logic [W2-1:0]    w_prod, w_prod_neg;

   // Single-cycle result path
   assign w_sum  = A + B;
   assign w_diff = A - B;
   assign w_sa   = (ALUOp == OP_SLLV || ALUOp == OP_SRLV || ALUOp == OP_SRAV) ? A[SHW-1:0] : shamt;

   always_comb begin
      Res = '0;
      case (ALUOp)
         OP_ADDU, OP_ADD: Res = w_sum;
         OP_SUBU, OP_SUB: Res = w_diff;
         OP_AND:          Res = A & B;
         OP_OR:           Res = A | B;
         OP_XOR:          Res = A ^ B;
         OP_NOR:          Res = ~(A | B);
         OP_SLT:          Res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_SLTU:         Res = {{(WIDTH-1){1'b0}}, (A < B)};
         OP_SLL, OP_SLLV: Res = B << w_sa;
         OP_SRL, OP_SRLV: Res = B >> w_sa;
         OP_SRA, OP_SRAV: Res = $unsigned($signed(B) >>> w_sa);
         OP_LUI:          Res = B << (WIDTH / 2);
         OP_MFHI:         Res = r_hi;
         OP_MFLO:         Res = r_lo;
         default:         Res = '0;
      endcase
   end

   always_comb begin
      OV = 1'b0;
      if (ALUOp == OP_ADD)
         OV = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      else if (ALUOp == OP_SUB)
         OV = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
   end

   assign ZF = (A == B);

   // Operand magnitudes and signs captured at launch
   assign w_sgn_op = (ALUOp == OP_MULT) || (ALUOp == OP_DIV);
   assign w_a_neg  = w_sgn_op & A[WIDTH-1];
   assign w_b_neg  = w_sgn_op & B[WIDTH-1];
   assign w_amag   = w_a_neg ? -A : A;
   assign w_bmag   = w_b_neg ? -B : B;

   // One iteration step of each algorithm
   assign w_mul_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
   assign w_div_sh   = {r_acc, r_q[WIDTH-1]};
   assign w_div_ge   = (w_div_sh >= {1'b0, r_m});
   assign w_div_diff = w_div_sh - {1'b0, r_m};
   assign w_prod     = {r_acc, r_q};
   assign w_prod_neg = -w_prod;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_go_mul   = 1'b0;
      w_go_div   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && (ALUOp == OP_MULT || ALUOp == OP_MULTU)) begin
               w_go_mul   = 1'b1;
               w_state_nx = S_MUL;
            end else if (start && (ALUOp == OP_DIV || ALUOp == OP_DIVU)) begin
               w_go_div   = 1'b1;
               w_state_nx = S_DIV;
            end
         end
         S_MUL, S_DIV: if (r_cnt == LAST_CNT) w_state_nx = S_FIX;
         S_FIX:        w_state_nx = S_IDLE;
         default:      w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_q      <= '0;
         r_m      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dvz    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_go_mul || w_go_div) begin
                  r_acc    <= '0;
                  r_q      <= w_amag;
                  r_m      <= w_bmag;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_is_div <= w_go_div;
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_dvz    <= (B == '0);
               end else if (ALUOp == OP_MTHI) begin
                  r_hi <= A;
               end else if (ALUOp == OP_MTLO) begin
                  r_lo <= A;
               end
            end
            S_MUL: begin
               r_acc <= w_mul_sum[WIDTH:1];
               r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
               r_cnt <= r_cnt + SHW'(1);
            end
            S_DIV: begin
               r_acc <= w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
               r_q   <= {r_q[WIDTH-2:0], w_div_ge};
               r_cnt <= r_cnt + SHW'(1);
            end
            S_FIX: begin
               // Divide-by-zero remainder already equals the dividend after sign fix
               if (r_is_div) begin
                  r_lo <= r_dvz ? '1 : (r_neg_q ? -r_q : r_q);
                  r_hi <= r_neg_r ? -r_acc : r_acc;
               end else begin
                  {r_hi, r_lo} <= r_neg_q ? w_prod_neg : w_prod;
               end
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed and random ALU and mul/div
// operations compared against a behavioural arithmetic model.
module tb_iter_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] A, B;
   logic [4:0]  ALUOp;
   logic [4:0]  shamt;
   logic        start;
   logic [31:0] Res, HI, LO;
   logic        ZF, OV, busy, done;

   int n_checks = 0;
   int n_err    = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   iter_alu #(.WIDTH(32), .SHW(5)) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .ALUOp(ALUOp), .shamt(shamt),
      .start(start), .Res(Res), .ZF(ZF), .OV(OV), .busy(busy), .done(done),
      .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sh, input logic [31:0] hi, input logic [31:0] lo);
      logic [4:0] s;
      s = (op >= 5'd13 && op <= 5'd15) ? a[4:0] : sh;
      case (op)
         5'd0, 5'd2:   return a + b;
         5'd1, 5'd3:   return a - b;
         5'd4:         return a & b;
         5'd5:         return a | b;
         5'd6:         return a ^ b;
         5'd7:         return ~(a | b);
         5'd8:         return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         5'd9:         return (a < b) ? 32'd1 : 32'd0;
         5'd10, 5'd13: return b << s;
         5'd11, 5'd14: return b >> s;
         5'd12, 5'd15: return 32'($signed(b) >>> s);
         5'd16:        return {b[15:0], 16'h0000};
         5'd21:        return hi;
         5'd22:        return lo;
         default:      return 32'd0;
      endcase
   endfunction

   function automatic logic ref_ov(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint r;
      if (op == 5'd2)      r = longint'($signed(a)) + longint'($signed(b));
      else if (op == 5'd3) r = longint'($signed(a)) - longint'($signed(b));
      else return 1'b0;
      return (r > 64'sd2147483647) || (r < -64'sd2147483648);
   endfunction

   function automatic void ref_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      hi = '0; lo = '0;
      case (op)
         5'd17: begin p = sa * sb; {hi, lo} = p; end
         5'd18: begin p = {32'h0, a} * {32'h0, b}; {hi, lo} = p; end
         5'd19: begin
            if (b == 0) begin hi = a; lo = '1; end
            else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
         end
         default: begin
            if (b == 0) begin hi = a; lo = '1; end
            else begin lo = a / b; hi = a % b; end
         end
      endcase
   endfunction

   task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
      ALUOp = op; A = a; B = b; shamt = sh;
      #1;
   endtask

   // Launch an iterative op, optionally poke contending inputs while busy
   task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit contend, input string tag);
      logic [31:0] eh, el, old_hi, old_lo;
      int nb;
      bit saw_done;
      ref_md(op, a, b, eh, el);
      old_hi = m_hi; old_lo = m_lo;
      ALUOp = op; A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; ALUOp = 5'd0; A = $urandom; B = $urandom;
      nb = 0; saw_done = 1'b0;
      while (busy === 1'b1 && nb < 100) begin
         nb++;
         if (done === 1'b1) saw_done = 1'b1;
         if (contend) begin
            case (nb)
               3: begin ALUOp = 5'd20; start = 1'b1; A = $urandom; B = $urandom; end
               4: begin start = 1'b0; ALUOp = 5'd24; A = 32'h55; end
               5: begin ALUOp = 5'd23; A = 32'h66; end
               6: begin ALUOp = 5'd22; #1; check({tag, " mflo-busy"}, 64'(Res), 64'(old_lo)); end
               7: begin ALUOp = 5'd21; #1; check({tag, " mfhi-busy"}, 64'(Res), 64'(old_hi)); end
               8: ALUOp = 5'd0;
               default: ;
            endcase
         end
         @(posedge clk); #1;
      end
      check({tag, " busy-cycles"}, 64'(nb), 64'd33);
      check({tag, " early-done"}, 64'(saw_done), 64'd0);
      check({tag, " done"}, 64'(done), 64'd1);
      check({tag, " HI"}, 64'(HI), 64'(eh));
      check({tag, " LO"}, 64'(LO), 64'(el));
      m_hi = eh; m_lo = el;
      @(posedge clk); #1;
      check({tag, " done-pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      logic [4:0]  op;
      logic [31:0] ra, rb;
      int nd;

      rst = 1'b1; start = 1'b0; ALUOp = 5'd0; A = '0; B = '0; shamt = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst HI", 64'(HI), 64'd0);
      check("rst LO", 64'(LO), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      rst = 1'b0;

      // Directed single-cycle cases
      drive(5'd10, 32'h0, 32'h80000001, 5'd4); check("sll", 64'(Res), 64'h00000010);
      drive(5'd11, 32'h0, 32'h80000001, 5'd4); check("srl", 64'(Res), 64'h08000000);
      drive(5'd12, 32'h0, 32'h80000001, 5'd4); check("sra", 64'(Res), 64'hF8000000);
      drive(5'd15, 32'hFFFFFFE4, 32'h80000001, 5'd0); check("srav", 64'(Res), 64'hF8000000);
      drive(5'd2, 32'h7FFFFFFF, 32'h1, 5'd0);
      check("add res", 64'(Res), 64'h80000000);
      check("add ov", 64'(OV), 64'd1);
      drive(5'd0, 32'h7FFFFFFF, 32'h1, 5'd0); check("addu ov", 64'(OV), 64'd0);
      drive(5'd8, 32'hFFFFFFFF, 32'h1, 5'd0); check("slt", 64'(Res), 64'd1);
      drive(5'd9, 32'hFFFFFFFF, 32'h1, 5'd0); check("sltu", 64'(Res), 64'd0);
      drive(5'd0, 32'h1234, 32'h1234, 5'd0); check("zf eq", 64'(ZF), 64'd1);
      drive(5'd3, 32'h80000000, 32'h1, 5'd0); check("sub ov", 64'(OV), 64'd1);
      drive(5'd16, 32'h0, 32'h0000ABCD, 5'd0); check("lui", 64'(Res), 64'hABCD0000);

      // Random single-cycle ops (no register writes)
      for (int i = 0; i < 150; i++) begin
         op = 5'($urandom_range(0, 31));
         if (op == 5'd23 || op == 5'd24) op = 5'd0;
         ra = $urandom; rb = (i % 7 == 0) ? ra : $urandom;
         drive(op, ra, rb, 5'($urandom));
         check("rand res", 64'(Res), 64'(ref_res(op, ra, rb, shamt, m_hi, m_lo)));
         check("rand ov", 64'(OV), 64'(ref_ov(op, ra, rb)));
         check("rand zf", 64'(ZF), 64'(ra == rb));
      end

      // MTHI/MTLO and MFHI/MFLO when idle
      ALUOp = 5'd23; A = 32'hCAFE0001; @(posedge clk); #1;
      check("mthi", 64'(HI), 64'hCAFE0001); m_hi = 32'hCAFE0001;
      ALUOp = 5'd24; A = 32'h0BADF00D; @(posedge clk); #1;
      check("mtlo", 64'(LO), 64'h0BADF00D); m_lo = 32'h0BADF00D;
      drive(5'd21, 32'h0, 32'h0, 5'd0); check("mfhi", 64'(Res), 64'(m_hi));
      drive(5'd22, 32'h0, 32'h0, 5'd0); check("mflo", 64'(Res), 64'(m_lo));
      ALUOp = 5'd0;

      // Directed iterative ops
      run_md(5'd17, 32'hFFFFFFFD, 32'd7, 1'b0, "mult");
      check("mult HI const", 64'(HI), 64'hFFFFFFFF);
      check("mult LO const", 64'(LO), 64'hFFFFFFEB);
      run_md(5'd18, 32'hFFFFFFFD, 32'd7, 1'b0, "multu");
      check("multu HI const", 64'(HI), 64'h00000006);
      run_md(5'd19, 32'hFFFFFFF9, 32'd2, 1'b0, "div");
      check("div LO const", 64'(LO), 64'hFFFFFFFD);
      check("div HI const", 64'(HI), 64'hFFFFFFFF);
      run_md(5'd20, 32'd7, 32'd0, 1'b0, "divu0");
      check("divu0 LO const", 64'(LO), 64'hFFFFFFFF);
      run_md(5'd19, 32'hFFFFFFF9, 32'd0, 1'b0, "div0 neg");
      run_md(5'd19, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div min");
      check("div min LO const", 64'(LO), 64'h80000000);

      // Random iterative ops
      for (int i = 0; i < 8; i++) begin
         op = 5'(17 + $urandom_range(0, 3));
         ra = $urandom;
         rb = (i == 5) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
         run_md(op, ra, rb, 1'b0, "rand md");
      end

      // Contention while busy
      run_md(5'd18, 32'h00012345, 32'h00000777, 1'b1, "contend");

      // Reset abort during DIVU
      ALUOp = 5'd20; A = 32'd100; B = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; ALUOp = 5'd0;
      repeat (9) @(posedge clk);
      #1;
      check("abort pre busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      check("abort busy", 64'(busy), 64'd0);
      check("abort HI", 64'(HI), 64'd0);
      check("abort LO", 64'(LO), 64'd0);
      m_hi = '0; m_lo = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      nd = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1) nd++;
      end
      check("abort no done", 64'(nd), 64'd0);
      check("abort idle", 64'(busy), 64'd0);
      run_md(5'd18, 32'd5, 32'd6, 1'b0, "post-rst multu");
      check("post-rst LO const", 64'(LO), 64'd30);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Parametrised next-generation ALU for the multi-cycle MIPS datapath.
- Keeps a single-cycle combinational path for the ALU/shift/compare ops. Shifts are corrected: SLL is left, SRL is logical right, and SRA/SRAV are added.
- Adds an iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake.
- The control FSM stalls on busy before issuing MFHI/MFLO.

Parameters:
- WIDTH, 32, datapath width (even, >=8).
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- A  in  WIDTH  operand A (rs).
- B  in  WIDTH  operand B (rt / extended immediate).
- ALUOp  in  5  operation select.
- shamt  in  SHW  constant shift amount.
- start  in  1  launch MULT/MULTU/DIV/DIVU (sampled only when ALUOp is one of them).
- Res  out  WIDTH  combinational result.
- ZF  out  1  (A==B), combinational.
- OV  out  1  signed overflow for ADD/SUB, else 0.
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse: HI/LO just written by an iterative op.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

Behaviour:
- ALUOp encoding (decimal), Res combinational:
  - 0 ADDU A+B; 1 SUBU A-B; 2 ADD A+B; 3 SUB A-B.
  - 4 AND; 5 OR; 6 XOR; 7 NOR.
  - 8 SLT signed A<B ->1/0; 9 SLTU unsigned.
  - 10 SLL B<<shamt; 11 SRL B>>shamt logical; 12 SRA B>>>shamt arithmetic.
  - 13 SLLV, 14 SRLV, 15 SRAV: as 10-12 using A[SHW-1:0], upper A bits ignored.
  - 16 LUI B<<(WIDTH/2).
  - 17 MULT; 18 MULTU; 19 DIV; 20 DIVU.
  - 21 MFHI Res=HI; 22 MFLO Res=LO.
  - 23 MTHI HI<=A; 24 MTLO LO<=A (both on clk edge).
  - 17-20, 23, 24 and undefined codes: Res=0.
- Arithmetic is modulo 2^WIDTH.
- OV = signed overflow for ops 2/3 only; no register write suppression inside this block.
- ZF is independent of ALUOp.
- Reset values: HI=0, LO=0, busy=0, done=0, FSM=IDLE, internal counter/accumulators=0. Res, ZF and OV follow inputs/HI/LO combinationally.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE:
  - start=1 with ALUOp 17/18 -> MUL; with ALUOp 19/20 -> DIV.
  - Operands captured at this edge. Signed ops store magnitudes plus a sign flag.
  - busy<=1, cnt<=0.
- MUL: shift-add, one multiplier bit per cycle; after WIDTH cycles -> FIX.
- DIV: restoring division, one quotient bit per cycle; after WIDTH cycles -> FIX.
- FIX:
  - Apply sign correction; write {HI,LO}.
  - busy<=0, done<=1 for exactly one cycle; -> IDLE.
- Timing:
  - start accepted at edge 0; busy high for WIDTH+1 cycles.
  - HI/LO valid and done=1 in the cycle after edge WIDTH+1.
  - A/B/ALUOp may change freely once start is accepted.
- Multiply result: HI:LO = full 2*WIDTH-bit product, signed (MULT) or unsigned (MULTU).
- Divide result:
  - LO=quotient, truncated toward zero; HI=remainder, sign of dividend.
  - Divide by zero: LO=all ones, HI=A (captured dividend); full latency, done pulses normally.
  - DIV of MIN by -1: LO=MIN, HI=0.
- Contention:
  - start while busy: ignored, no restart.
  - MTHI/MTLO while busy: ignored.
  - MFHI/MFLO while busy: return current (pre-operation) registers.
  - MTHI/MTLO in the FIX cycle: FIX write wins.
  - start and MTHI in the same cycle is impossible (different ALUOp).
- rst asserted mid-operation: immediate abort; all state returns to reset values, no done pulse.

Test Plan:
- Shifts: B=0x80000001, shamt=4.
  - SLL -> 0x00000010; SRL -> 0x08000000; SRA -> 0xF8000000.
  - SRAV with A=0xFFFFFFE4 (low 5 bits = 4) -> 0xF8000000.
- Overflow and compares:
  - ADD 0x7FFFFFFF+1 -> Res=0x80000000, OV=1; ADDU same operands -> OV=0.
  - SLT 0xFFFFFFFF vs 1 -> 1; SLTU -> 0; ZF=1 when A=B=0x1234.
- MULT: A=-3 (0xFFFFFFFD), B=7, start.
  - busy high 33 cycles, then done pulse.
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - MULTU same operands -> HI=0x00000006, LO=0xFFFFFFEB.
- DIV: A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Contention:
  - During busy: second start, and MTLO A=0x55, both produce no effect.
  - MFLO while busy returns the old LO; final LO equals the first operation's result.
- Reset at cycle 10 of a DIVU: busy=0, HI=LO=0 immediately, no done.
  - A new MULTU 5*6 afterwards -> LO=30, HI=0.
